// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int unsigned PC_INC = 4;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with enable, bubble clear and async reset
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            clr,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    input  logic            valid_in,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);
    logic [XLEN-1:0] instr_q, instr_n, pc_plus4_q, pc_plus4_n;
    logic            valid_q, valid_n;

    // load, bubble or hold the decode-side register
    always_comb begin
        instr_n    = en ? (clr ? XLEN'(NOP_INSTR) : instr_in) : instr_q;
        pc_plus4_n = en ? (clr ? '0 : pc_plus4_in) : pc_plus4_q;
        valid_n    = en ? (~clr & valid_in) : valid_q;
    end

    // register update with asynchronous clear to a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= XLEN'(NOP_INSTR);
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_n;
            pc_plus4_q <= pc_plus4_n;
            valid_q    <= valid_n;
        end
    end

    assign instr_d    = instr_q;
    assign pc_plus4_d = pc_plus4_q;
    assign valid_d    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem req/ready handshake, redirect squashing and IF/ID register
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            pc_src_d,
    input  logic [XLEN-1:0] branch_target_d,
    input  logic            jump_d,
    input  logic [XLEN-1:0] jump_target_d,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            fetch_busy
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, hold_q, hold_d, stale_q, stale_d;
    logic            stall, redirect, load_fetch, load_hold;
    logic [XLEN-1:0] target, pc_inc;

    // handshake outputs; request is suppressed while reset is asserted
    always_comb begin
        imem_req   = ~reset & (state_q != HOLD);
        imem_addr  = (state_q == DISCARD) ? stale_q : pc_q;
        fetch_busy = ~reset & (((state_q == FETCH) & ~imem_ready) | (state_q == DISCARD));
    end

    // prioritised next-state: redirect, accept, hold, release, discard, idle
    always_comb begin
        stall      = stall_f | stall_d;
        redirect   = ~stall & (jump_d | pc_src_d);
        target     = jump_d ? jump_target_d : branch_target_d;
        pc_inc     = pc_q + XLEN'(PC_INC);
        load_fetch = ~redirect & (state_q == FETCH) & imem_ready & ~stall;
        load_hold  = ~redirect & (state_q == HOLD) & ~stall;
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        stale_d    = stale_q;
        if (redirect) begin
            pc_d    = target;
            hold_d  = '0;
            state_d = (state_q != HOLD && !imem_ready) ? DISCARD : FETCH;
            if (state_q == FETCH && !imem_ready) stale_d = pc_q;
        end else if (load_fetch) begin
            pc_d = pc_inc;
        end else if (state_q == FETCH && imem_ready) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
        end else if (load_hold) begin
            pc_d    = pc_inc;
            state_d = FETCH;
        end else if (state_q == DISCARD && imem_ready) begin
            state_d = FETCH;
        end
    end

    // fetch state, PC, hold buffer and stale address registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= XLEN'(RESET_PC);
            hold_q  <= '0;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            stale_q <= stale_d;
        end
    end

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .en         (~stall),
        .clr        (~(load_fetch | load_hold)),
        .instr_in   (load_hold ? hold_q : imem_rdata),
        .pc_plus4_in(pc_inc),
        .valid_in   (1'b1),
        .instr_d    (instr_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed values
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, stall_f, stall_d, pc_src_d, jump_d, imem_ready;
    logic [31:0] branch_target_d, jump_target_d, imem_rdata, imem_addr, instr_d, pc_plus4_d;
    logic        imem_req, valid_d, fetch_busy;
    int          n_chk = 0, n_pass = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
        .pc_src_d(pc_src_d), .branch_target_d(branch_target_d),
        .jump_d(jump_d), .jump_target_d(jump_target_d),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4, input logic v);
        chk({tag, "_instr"}, instr_d, ins);
        chk({tag, "_pc4"}, pc_plus4_d, p4);
        chk({tag, "_valid"}, 32'(valid_d), 32'(v));
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; pc_src_d = 1'b0; jump_d = 1'b0;
        imem_ready = 1'b1; branch_target_d = '0; jump_target_d = '0;
        repeat (2) tick();
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_busy", 32'(fetch_busy), 0);
        ifid("rst", 0, 0, 0);
        reset = 1'b0; #1;
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req", 32'(imem_req), 1);
        tick(); ifid("s0", 32'hC0DE0000, 32'h4, 1); chk("s0_addr", imem_addr, 32'h4);
        tick(); ifid("s1", 32'hC0DE0004, 32'h8, 1); chk("s1_addr", imem_addr, 32'h8);
        tick(); ifid("s2", 32'hC0DE0008, 32'hC, 1); chk("s2_addr", imem_addr, 32'hC);
        imem_ready = 1'b0; #1;
        chk("wait_busy0", 32'(fetch_busy), 1);
        tick(); chk("wait1_valid", 32'(valid_d), 0); chk("wait1_addr", imem_addr, 32'hC); chk("wait1_busy", 32'(fetch_busy), 1);
        tick(); chk("wait2_valid", 32'(valid_d), 0); chk("wait2_addr", imem_addr, 32'hC);
        imem_ready = 1'b1; #1;
        chk("wait_busy_done", 32'(fetch_busy), 0);
        tick(); ifid("wait_done", 32'hC0DE000C, 32'h10, 1); chk("wait_done_addr", imem_addr, 32'h10);
        stall_f = 1'b1; stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            ifid("hold", 32'hC0DE000C, 32'h10, 1);
            chk("hold_req", 32'(imem_req), 0);
        end
        stall_f = 1'b0; stall_d = 1'b0;
        tick(); ifid("hold_rel", 32'hC0DE0010, 32'h14, 1);
        chk("hold_rel_addr", imem_addr, 32'h14); chk("hold_rel_req", 32'(imem_req), 1);
        imem_ready = 1'b0; pc_src_d = 1'b1; branch_target_d = 32'h40;
        tick(); chk("disc_valid", 32'(valid_d), 0); chk("disc_addr", imem_addr, 32'h14); chk("disc_busy", 32'(fetch_busy), 1);
        pc_src_d = 1'b0;
        tick(); chk("disc2_addr", imem_addr, 32'h14); chk("disc2_req", 32'(imem_req), 1);
        imem_ready = 1'b1;
        tick(); chk("disc_drop_valid", 32'(valid_d), 0); chk("disc_drop_addr", imem_addr, 32'h40);
        tick(); ifid("br_tgt", 32'hC0DE0040, 32'h44, 1); chk("br_tgt_addr", imem_addr, 32'h44);
        jump_d = 1'b1; jump_target_d = 32'h100; pc_src_d = 1'b1; branch_target_d = 32'h40;
        stall_f = 1'b1; stall_d = 1'b1;
        tick(); ifid("jmp_stall", 32'hC0DE0040, 32'h44, 1); chk("jmp_stall_addr", imem_addr, 32'h44);
        stall_f = 1'b0; stall_d = 1'b0;
        tick(); chk("jmp_valid", 32'(valid_d), 0); chk("jmp_addr", imem_addr, 32'h100);
        jump_d = 1'b0; pc_src_d = 1'b0;
        tick(); ifid("jmp_tgt", 32'hC0DE0100, 32'h104, 1);
        imem_ready = 1'b0; pc_src_d = 1'b1; branch_target_d = 32'h200;
        tick(); chk("rd_addr", imem_addr, 32'h104); chk("rd_busy", 32'(fetch_busy), 1);
        pc_src_d = 1'b0;
        #2 reset = 1'b1; #1;
        ifid("async_rst", 0, 0, 0);
        chk("async_rst_req", 32'(imem_req), 0);
        chk("async_rst_busy", 32'(fetch_busy), 0);
        tick();
        reset = 1'b0; imem_ready = 1'b1; #1;
        chk("rst2_addr", imem_addr, 32'h0);
        jump_d = 1'b1; jump_target_d = 32'hFFFF_FFFC;
        tick(); chk("wrap_jmp_valid", 32'(valid_d), 0); chk("wrap_jmp_addr", imem_addr, 32'hFFFF_FFFC);
        jump_d = 1'b0;
        tick(); ifid("wrap", 32'hC0DEFFFC, 32'h0, 1); chk("wrap_addr", imem_addr, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
